// File: rtl/mips_pc_pkg.sv
//------------------------------------------------------------------------------
// Module : mips_pc_pkg
// Brief  : Shared constants, state and next-PC select encodings for pc_unit.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pc_pkg;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        HOLD_PEND = 1'b1
    } pc_state_t;

    // Priority-resolved source of a new redirect; the pending leg is muxed separately.
    localparam logic [1:0] c_SEL_SEQ = 2'b00;
    localparam logic [1:0] c_SEL_BR  = 2'b01;
    localparam logic [1:0] c_SEL_J   = 2'b10;
    localparam logic [1:0] c_SEL_JR  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pc_unit_adder_32.sv
//------------------------------------------------------------------------------
// Module : adder_32
// Brief  : 32-bit ripple-carry adder, sum modulo 2^32 (carry-out dropped).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic [31:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 32; i = i + 1) begin : g_bit
            assign sum[i] = a[i] ^ b[i] ^ w_carry[i];
            if (i < 31) begin : g_carry
                assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
//------------------------------------------------------------------------------
// Module : pc_unit
// Brief  : Program counter with prioritized redirects, stall and buffered redirect.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] shifted_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic        misaligned_err
);

    pc_state_t   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_target;
    logic        r_misaligned;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_jr_target;
    logic [1:0]  w_sel;
    logic        w_new_redir;
    logic [31:0] w_new_target;

    adder_32 u_add_plus4 (
        .a   (r_pc),
        .b   (32'd4),
        .sum (w_pc_plus4)
    );

    adder_32 u_add_branch (
        .a   (w_pc_plus4),
        .b   (shifted_offset),
        .sum (w_branch_target)
    );

    assign w_jump_target = {w_pc_plus4[31:28], jump_index, 2'b00};
    assign w_jr_target   = {jr_addr[31:2], 2'b00};
    assign w_new_redir   = jr | jump | branch_taken;

    always_comb begin
        w_sel = c_SEL_SEQ;
        if (jr)
            w_sel = c_SEL_JR;
        else if (jump)
            w_sel = c_SEL_J;
        else if (branch_taken)
            w_sel = c_SEL_BR;
    end

    always_comb begin
        w_new_target = w_pc_plus4;
        case (w_sel)
            c_SEL_JR:  w_new_target = w_jr_target;
            c_SEL_J:   w_new_target = w_jump_target;
            c_SEL_BR:  w_new_target = w_branch_target;
            c_SEL_SEQ: w_new_target = w_pc_plus4;
            default:   w_new_target = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_state       <= RUN;
            r_pend_target <= 32'h0;
            r_misaligned  <= 1'b0;
        end else begin
            // Flag tracks any JR request, even one that loses priority or is stalled.
            if (jr && (jr_addr[1:0] != 2'b00))
                r_misaligned <= 1'b1;

            if (!stall) begin
                if (w_new_redir) begin
                    r_pc    <= w_new_target;
                    r_state <= RUN;
                end else if (r_state == HOLD_PEND) begin
                    r_pc    <= r_pend_target;
                    r_state <= RUN;
                end else begin
                    r_pc <= w_pc_plus4;
                end
            end else if (w_new_redir) begin
                r_pend_target <= w_new_target;
                r_state       <= HOLD_PEND;
            end
        end
    end

    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign redirect_pending = (r_state == HOLD_PEND);
    assign misaligned_err   = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//------------------------------------------------------------------------------
// Module : tb_pc_unit
// Brief  : Scoreboard bench for pc_unit: directed scenarios then random traffic.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] shifted_offset = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_pending;
    logic        misaligned_err;

    pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .shifted_offset   (shifted_offset),
        .jump             (jump),
        .jump_index       (jump_index),
        .jr               (jr),
        .jr_addr          (jr_addr),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .redirect_pending (redirect_pending),
        .misaligned_err   (misaligned_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state: the pending redirect is a queue of at most one target.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_pend_q[$];
    logic        m_mis = 1'b0;

    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] tgt;
        logic        any;
        exp_t        e;
        p4  = m_pc + 32'd4;
        any = jr | jump | branch_taken;
        if (jr)             tgt = {jr_addr[31:2], 2'b00};
        else if (jump)      tgt = {p4[31:28], jump_index, 2'b00};
        else                tgt = p4 + shifted_offset;
        if (reset) begin
            m_pc = RESET_PC;
            m_pend_q.delete();
            m_mis = 1'b0;
        end else begin
            if (jr && jr_addr[1:0] != 2'b00) m_mis = 1'b1;
            if (!stall) begin
                if (any) begin
                    m_pc = tgt;
                    m_pend_q.delete();
                end else if (m_pend_q.size() != 0) begin
                    m_pc = m_pend_q.pop_front();
                end else begin
                    m_pc = p4;
                end
            end else if (any) begin
                m_pend_q.delete();
                m_pend_q.push_back(tgt);
            end
        end
        e.pc   = m_pc;
        e.pend = (m_pend_q.size() != 0);
        e.mis  = m_mis;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and record the expected result.
    task automatic cyc(input logic rst, input logic stl, input logic br, input logic [31:0] off,
                       input logic j, input logic [25:0] idx, input logic r, input logic [31:0] addr);
        @(negedge clk);
        reset = rst; stall = stl; branch_taken = br; shifted_offset = off;
        jump = j; jump_index = idx; jr = r; jr_addr = addr;
        model_step();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic go_jr(input logic [31:0] addr);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, addr);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("redirect_pending", {31'h0, redirect_pending}, {31'h0, e.pend});
            chk("misaligned_err", {31'h0, misaligned_err}, {31'h0, e.mis});
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        repeat (3) idle();

        go_jr(32'h100);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0, 1'b0, 32'h0);
        go_jr(32'h100);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 26'h40, 1'b0, 32'h0);

        go_jr(32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h1000);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        idle();

        go_jr(32'h200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h1000);
        cyc(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 26'h0, 1'b0, 32'h0);

        go_jr(32'h3003);
        repeat (5) idle();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h40);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);

        go_jr(32'hFFFF_FFFC);
        idle();
        go_jr(32'h4000_0000);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] addr;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom,
                $urandom_range(0, 5) == 0, 26'($urandom),
                $urandom_range(0, 7) == 0, addr);
        end

        idle();
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
